// File: rtl/madgwick_top.sv
// Wishbone register wrapper around the Madgwick quaternion filter core.
// This file also holds a latency-matched stand-in for madgwick_core. It accepts one
// sample set and, a fixed number of cycles later, returns a constant quaternion.

module madgwick_core #(
   parameter int unsigned ACC_WIDTH  = 16,
   parameter int unsigned GYRO_WIDTH = 16,
   parameter int unsigned Q_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ACC_WIDTH-1:0]  a_x,
   input  logic [ACC_WIDTH-1:0]  a_y,
   input  logic [ACC_WIDTH-1:0]  a_z,
   input  logic [GYRO_WIDTH-1:0] w_x,
   input  logic [GYRO_WIDTH-1:0] w_y,
   input  logic [GYRO_WIDTH-1:0] w_z,
   input  logic                  valid_in,
   output logic                  ready_in,
   output logic [Q_WIDTH-1:0]    q_w,
   output logic [Q_WIDTH-1:0]    q_x,
   output logic [Q_WIDTH-1:0]    q_y,
   output logic [Q_WIDTH-1:0]    q_z,
   output logic                  valid_out,
   input  logic                  ready_out
);
   logic       busy;
   logic [1:0] cnt;
   logic       unused_samples;

   // The stand-in does not look at the sample values.
   assign unused_samples = ^{a_x, a_y, a_z, w_x, w_y, w_z};

   assign ready_in = !busy;
   assign q_w      = Q_WIDTH'(32'h4000_0000);
   assign q_x      = Q_WIDTH'(1);
   assign q_y      = Q_WIDTH'(2);
   assign q_z      = Q_WIDTH'(3);

   // Accept a sample set, count out the latency, then present the result until it is taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         cnt       <= '0;
         valid_out <= 1'b0;
      end else if (!busy) begin
         if (valid_in) begin
            busy <= 1'b1;
            cnt  <= '0;
         end
      end else if (valid_out) begin
         if (ready_out) begin
            valid_out <= 1'b0;
            busy      <= 1'b0;
         end
      end else if (cnt == 2'd2) begin
         valid_out <= 1'b1;
      end else begin
         cnt <= cnt + 2'd1;
      end
   end
endmodule

module madgwick_top (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  adr_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   input  logic        we_i,
   input  logic        stb_i,
   input  logic        cyc_i,
   output logic        ack_o,
   output logic        inta_o,
   output logic [15:0] a_x_debug,
   output logic [15:0] a_y_debug,
   output logic [15:0] a_z_debug,
   output logic [15:0] w_x_debug,
   output logic [15:0] w_y_debug,
   output logic [15:0] w_z_debug,
   output logic [31:0] q_w_debug,
   output logic [31:0] q_x_debug,
   output logic [31:0] q_y_debug,
   output logic [31:0] q_z_debug,
   output logic        enable_debug,
   output logic        start_debug,
   output logic        done_debug,
   output logic        int_enable_debug,
   output logic        rst_n_madgwick_debug,
   output logic        valid_in_madgwick_debug,
   output logic        ready_in_madgwick_debug,
   output logic        valid_out_madgwick_debug,
   output logic        ready_out_madgwick_debug
);
   localparam int unsigned ACC_WIDTH  = 16;
   localparam int unsigned GYRO_WIDTH = 16;
   localparam int unsigned Q_WIDTH    = 32;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

   state_t                state;
   logic                  enable, start, done, int_en, valid_in;
   logic [ACC_WIDTH-1:0]  a_x, a_y, a_z;
   logic [GYRO_WIDTH-1:0] w_x, w_y, w_z;
   logic [Q_WIDTH-1:0]    q_w, q_x, q_y, q_z;
   logic [Q_WIDTH-1:0]    core_q_w, core_q_x, core_q_y, core_q_z;
   logic                  core_ready_in, core_valid_out, core_rst_n;
   logic                  access, wr, rd, ctrl_wr;
   logic [31:0]           rdata;
   logic                  unused_bus;

   // Only the low data bits and the word address are decoded.
   assign unused_bus = ^{dat_i[31:16], adr_i[1:0]};

   assign access  = stb_i && cyc_i && !ack_o;
   assign wr      = access && we_i;
   assign rd      = access && !we_i;
   assign ctrl_wr = wr && (adr_i[5:2] == 4'h0);

   assign core_rst_n = !rst && enable;
   assign inta_o     = done && int_en;

   madgwick_core #(
      .ACC_WIDTH (ACC_WIDTH),
      .GYRO_WIDTH(GYRO_WIDTH),
      .Q_WIDTH   (Q_WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (core_rst_n),
      .a_x      (a_x),
      .a_y      (a_y),
      .a_z      (a_z),
      .w_x      (w_x),
      .w_y      (w_y),
      .w_z      (w_z),
      .valid_in (valid_in),
      .ready_in (core_ready_in),
      .q_w      (core_q_w),
      .q_x      (core_q_x),
      .q_y      (core_q_y),
      .q_z      (core_q_z),
      .valid_out(core_valid_out),
      .ready_out(1'b1)
   );

   // Bus acknowledge: a single pulse per strobe, even if the strobe is held.
   always_ff @(posedge clk) begin
      if (rst) ack_o <= 1'b0;
      else     ack_o <= stb_i && cyc_i && !ack_o;
   end

   // Read data mux; samples are sign-extended to the bus width.
   always_comb begin
      rdata = '0;
      case (adr_i[5:2])
         4'h0: rdata = {28'd0, int_en, done, start, enable};
         4'h1: rdata = {{(32-ACC_WIDTH){a_x[ACC_WIDTH-1]}}, a_x};
         4'h2: rdata = {{(32-ACC_WIDTH){a_y[ACC_WIDTH-1]}}, a_y};
         4'h3: rdata = {{(32-ACC_WIDTH){a_z[ACC_WIDTH-1]}}, a_z};
         4'h4: rdata = {{(32-GYRO_WIDTH){w_x[GYRO_WIDTH-1]}}, w_x};
         4'h5: rdata = {{(32-GYRO_WIDTH){w_y[GYRO_WIDTH-1]}}, w_y};
         4'h6: rdata = {{(32-GYRO_WIDTH){w_z[GYRO_WIDTH-1]}}, w_z};
         4'h7: rdata = q_w;
         4'h8: rdata = q_x;
         4'h9: rdata = q_y;
         4'hA: rdata = q_z;
         default: rdata = '0;
      endcase
   end

   // Registered read data, loaded with the ack and held until the next read.
   always_ff @(posedge clk) begin
      if (rst)     dat_o <= '0;
      else if (rd) dat_o <= rdata;
   end

   // Sample registers, committed on the acknowledging edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_x <= '0; a_y <= '0; a_z <= '0;
         w_x <= '0; w_y <= '0; w_z <= '0;
      end else if (wr) begin
         case (adr_i[5:2])
            4'h1: a_x <= dat_i[ACC_WIDTH-1:0];
            4'h2: a_y <= dat_i[ACC_WIDTH-1:0];
            4'h3: a_z <= dat_i[ACC_WIDTH-1:0];
            4'h4: w_x <= dat_i[GYRO_WIDTH-1:0];
            4'h5: w_y <= dat_i[GYRO_WIDTH-1:0];
            4'h6: w_z <= dat_i[GYRO_WIDTH-1:0];
            default: ;
         endcase
      end
   end

   // Control register and core sequencing FSM; CTRL writes override the normal step.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         enable   <= 1'b0;
         start    <= 1'b0;
         int_en   <= 1'b0;
         done     <= 1'b0;
         valid_in <= 1'b0;
         q_w      <= '0;
         q_x      <= '0;
         q_y      <= '0;
         q_z      <= '0;
      end else begin
         case (state)
            S_IDLE: if (enable && start && !done) begin
               state    <= S_SEND;
               valid_in <= 1'b1;
            end
            S_SEND: if (valid_in && core_ready_in) begin
               state    <= S_WAIT;
               valid_in <= 1'b0;
            end
            S_WAIT: if (core_valid_out) begin
               state <= S_DONE;
               done  <= 1'b1;
               q_w   <= core_q_w;
               q_x   <= core_q_x;
               q_y   <= core_q_y;
               q_z   <= core_q_z;
            end
            S_DONE: ;
            default: state <= S_IDLE;
         endcase
         if (ctrl_wr) begin
            enable <= dat_i[0];
            start  <= dat_i[1];
            int_en <= dat_i[3];
            if (!dat_i[0]) begin
               state    <= S_IDLE;
               done     <= 1'b0;
               valid_in <= 1'b0;
            end else if (state == S_DONE && !dat_i[1]) begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
         end
      end
   end

   assign a_x_debug                = a_x;
   assign a_y_debug                = a_y;
   assign a_z_debug                = a_z;
   assign w_x_debug                = w_x;
   assign w_y_debug                = w_y;
   assign w_z_debug                = w_z;
   assign q_w_debug                = q_w;
   assign q_x_debug                = q_x;
   assign q_y_debug                = q_y;
   assign q_z_debug                = q_z;
   assign enable_debug             = enable;
   assign start_debug              = start;
   assign done_debug               = done;
   assign int_enable_debug         = int_en;
   assign rst_n_madgwick_debug     = core_rst_n;
   assign valid_in_madgwick_debug  = valid_in;
   assign ready_in_madgwick_debug  = core_ready_in;
   assign valid_out_madgwick_debug = core_valid_out;
   assign ready_out_madgwick_debug = 1'b1;
endmodule

// File: tb/tb_madgwick_top.sv
// Directed bench for madgwick_top: register access, filter run sequencing, interrupt, abort.

module tb_madgwick_top;
   logic        clk, rst;
   logic [5:0]  adr_i;
   logic [31:0] dat_i, dat_o;
   logic        we_i, stb_i, cyc_i, ack_o, inta_o;
   logic [15:0] a_x_debug, a_y_debug, a_z_debug, w_x_debug, w_y_debug, w_z_debug;
   logic [31:0] q_w_debug, q_x_debug, q_y_debug, q_z_debug;
   logic        enable_debug, start_debug, done_debug, int_enable_debug;
   logic        rst_n_madgwick_debug, valid_in_madgwick_debug, ready_in_madgwick_debug;
   logic        valid_out_madgwick_debug, ready_out_madgwick_debug;

   int checks   = 0;
   int failures = 0;

   madgwick_top dut (
      .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
      .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .inta_o(inta_o),
      .a_x_debug(a_x_debug), .a_y_debug(a_y_debug), .a_z_debug(a_z_debug),
      .w_x_debug(w_x_debug), .w_y_debug(w_y_debug), .w_z_debug(w_z_debug),
      .q_w_debug(q_w_debug), .q_x_debug(q_x_debug), .q_y_debug(q_y_debug), .q_z_debug(q_z_debug),
      .enable_debug(enable_debug), .start_debug(start_debug), .done_debug(done_debug),
      .int_enable_debug(int_enable_debug), .rst_n_madgwick_debug(rst_n_madgwick_debug),
      .valid_in_madgwick_debug(valid_in_madgwick_debug),
      .ready_in_madgwick_debug(ready_in_madgwick_debug),
      .valid_out_madgwick_debug(valid_out_madgwick_debug),
      .ready_out_madgwick_debug(ready_out_madgwick_debug)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wb_write(input logic [5:0] a, input logic [31:0] d, input bit hold);
      @(negedge clk);
      adr_i = a; dat_i = d; we_i = 1'b1; stb_i = 1'b1; cyc_i = 1'b1;
      @(posedge clk); #1;
      check("wr_ack", {31'd0, ack_o}, 32'd1);
      if (hold) begin
         @(posedge clk); #1;
         check("wr_hold_no_second_ack", {31'd0, ack_o}, 32'd0);
      end
      @(negedge clk);
      we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
   endtask

   task automatic wb_read(input logic [5:0] a, output logic [31:0] d);
      @(negedge clk);
      adr_i = a; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1;
      @(posedge clk); #1;
      check("rd_ack", {31'd0, ack_o}, 32'd1);
      d = dat_o;
      @(negedge clk);
      stb_i = 1'b0; cyc_i = 1'b0;
   endtask

   task automatic poll_done(input string tag);
      logic [31:0] d;
      logic        seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         wb_read(6'h00, d);
         if (d[2]) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, {31'd0, seen}, 32'd1);
   endtask

   logic [31:0] rd;
   int          done_seen;

   initial begin
      rst = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_ack", {31'd0, ack_o}, 32'd0);
      check("reset_inta", {31'd0, inta_o}, 32'd0);
      check("reset_core_rst_n", {31'd0, rst_n_madgwick_debug}, 32'd0);
      check("reset_ready_out", {31'd0, ready_out_madgwick_debug}, 32'd1);
      check("reset_valid_in", {31'd0, valid_in_madgwick_debug}, 32'd0);
      check("reset_dat_o", dat_o, 32'd0);
      wb_read(6'h00, rd);
      check("reset_ctrl", rd, 32'h0000_0000);

      // Enable with interrupt; strobe held through the ack cycle.
      wb_write(6'h00, 32'h09, 1'b1);
      wb_read(6'h00, rd);
      check("ctrl_09", rd, 32'h0000_0009);
      check("core_rst_n_enabled", {31'd0, rst_n_madgwick_debug}, 32'd1);
      check("int_en_debug", {31'd0, int_enable_debug}, 32'd1);

      // Sample registers and sign extension.
      wb_write(6'h04, 32'h0000_1838, 1'b0);
      wb_read(6'h04, rd);
      check("a_x_read", rd, 32'h0000_1838);
      check("a_x_debug", {16'd0, a_x_debug}, 32'h0000_1838);
      wb_write(6'h10, 32'h0000_FC1F, 1'b0);
      wb_read(6'h10, rd);
      check("w_x_signext", rd, 32'hFFFF_FC1F);
      wb_write(6'h0C, 32'hFFFF_8000, 1'b0);
      wb_read(6'h0C, rd);
      check("a_z_signext_min", rd, 32'hFFFF_8000);
      wb_write(6'h18, 32'h0001_7FFF, 1'b0);
      wb_read(6'h18, rd);
      check("w_z_trunc_max", rd, 32'h0000_7FFF);

      // q registers are read-only.
      wb_write(6'h1C, 32'h0000_1234, 1'b0);
      wb_read(6'h1C, rd);
      check("q_w_ro", rd, 32'h0000_0000);

      // Run with interrupt enabled.
      wb_write(6'h00, 32'h0B, 1'b0);
      @(posedge clk); #1;
      check("valid_in_after_start", {31'd0, valid_in_madgwick_debug}, 32'd1);
      poll_done("run1_done_poll");
      wb_read(6'h00, rd);
      check("run1_ctrl_done", rd, 32'h0000_000F);
      check("run1_inta", {31'd0, inta_o}, 32'd1);
      wb_write(6'h00, 32'h09, 1'b0);
      #1;
      check("run1_done_cleared", {31'd0, done_debug}, 32'd0);
      check("run1_inta_cleared", {31'd0, inta_o}, 32'd0);
      wb_read(6'h00, rd);
      check("run1_ctrl_after_clear", rd, 32'h0000_0009);
      wb_read(6'h1C, rd);
      check("q_w", rd, 32'h4000_0000);
      wb_read(6'h20, rd);
      check("q_x", rd, 32'h0000_0001);
      wb_read(6'h24, rd);
      check("q_y", rd, 32'h0000_0002);
      wb_read(6'h28, rd);
      check("q_z", rd, 32'h0000_0003);

      // Run without interrupt enable.
      wb_write(6'h00, 32'h03, 1'b0);
      poll_done("run2_done_poll");
      wb_read(6'h00, rd);
      check("run2_ctrl_done", rd, 32'h0000_0007);
      check("run2_inta_masked", {31'd0, inta_o}, 32'd0);
      wb_write(6'h00, 32'h01, 1'b0);
      wb_read(6'h00, rd);
      check("run2_ctrl_after_clear", rd, 32'h0000_0001);

      // Abort a run by dropping enable before the result arrives.
      wb_write(6'h00, 32'h0B, 1'b0);
      wb_write(6'h00, 32'h08, 1'b0);
      #1;
      check("abort_valid_in", {31'd0, valid_in_madgwick_debug}, 32'd0);
      check("abort_core_rst_n", {31'd0, rst_n_madgwick_debug}, 32'd0);
      check("abort_enable", {31'd0, enable_debug}, 32'd0);
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done_debug) done_seen++;
      end
      check("abort_done_never", done_seen, 32'd0);
      wb_read(6'h00, rd);
      check("abort_ctrl", rd, 32'h0000_0008);
      wb_read(6'h2C, rd);
      check("unmapped_read", rd, 32'h0000_0000);
      wb_read(6'h1C, rd);
      check("q_w_retained", rd, 32'h4000_0000);

      // Reset in the middle of a strobe.
      @(negedge clk);
      adr_i = 6'h00; we_i = 1'b0; stb_i = 1'b1; cyc_i = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      check("midreset_ack", {31'd0, ack_o}, 32'd0);
      check("midreset_q_w", q_w_debug, 32'd0);
      check("midreset_int_en", {31'd0, int_enable_debug}, 32'd0);
      @(negedge clk);
      stb_i = 1'b0; cyc_i = 1'b0; rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
